// File: rtl/wisc_pkg.sv
// -----------------------------------------------------------------------------
// wisc_pkg
// Shared definitions for the WISC-F18 5-stage core front end:
//   - opcode_e      : 4-bit opcode encodings (OP_ADD .. OP_B, OP_HLT)
//   - NOP_INSTR     : bubble encoding (ADD r0,r0,r0; r0 is hardwired so harmless)
//   - field offsets : bit positions used to slice an instruction for decode
// -----------------------------------------------------------------------------
package wisc_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LW     = 4'h8,
    OP_SW     = 4'h9,
    OP_LHB    = 4'hA,
    OP_LLB    = 4'hB,
    OP_B      = 4'hC,
    OP_BR     = 4'hD,
    OP_PCS    = 4'hE,
    OP_HLT    = 4'hF
  } opcode_e;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  localparam int OPC_HI = 15;
  localparam int RD_LO  = 8;
  localparam int RS_LO  = 4;
  localparam int RT_LO  = 0;
  localparam int IMM9_W = 9;

endpackage

// File: rtl/if_id_stage_if.sv
// -----------------------------------------------------------------------------
// if_id_stage_if
// Bundle between fetch/hazard logic (master) and the IF/ID register (slave).
//   master drives : Instr_in, PC_plus2_in, Fetch_valid, Stall, Flush
//   slave drives  : Instr_out, PC_plus2_out, Valid_out, Opcode, Imme_9b,
//                   Rd, Rs, Rt, Halt_pending, Halt_seen, Fetch_stop
// Optional macro IF_ID_PERF_CNT_EN adds slave outputs Bubble_cnt, Stall_cnt.
// -----------------------------------------------------------------------------
interface if_id_stage_if #(
  parameter int INSTR_W = 16,
  parameter int PC_W    = 16
);

  logic [INSTR_W-1:0] Instr_in;
  logic [PC_W-1:0]    PC_plus2_in;
  logic               Fetch_valid;
  logic               Stall;
  logic               Flush;

  logic [INSTR_W-1:0] Instr_out;
  logic [PC_W-1:0]    PC_plus2_out;
  logic               Valid_out;
  logic [3:0]         Opcode;
  logic [8:0]         Imme_9b;
  logic [3:0]         Rd;
  logic [3:0]         Rs;
  logic [3:0]         Rt;
  logic               Halt_pending;
  logic               Halt_seen;
  logic               Fetch_stop;

`ifdef IF_ID_PERF_CNT_EN
  logic [15:0]        Bubble_cnt;
  logic [15:0]        Stall_cnt;

  modport master (
    output Instr_in, PC_plus2_in, Fetch_valid, Stall, Flush,
    input  Instr_out, PC_plus2_out, Valid_out, Opcode, Imme_9b, Rd, Rs, Rt,
           Halt_pending, Halt_seen, Fetch_stop, Bubble_cnt, Stall_cnt
  );

  modport slave (
    input  Instr_in, PC_plus2_in, Fetch_valid, Stall, Flush,
    output Instr_out, PC_plus2_out, Valid_out, Opcode, Imme_9b, Rd, Rs, Rt,
           Halt_pending, Halt_seen, Fetch_stop, Bubble_cnt, Stall_cnt
  );
`else
  modport master (
    output Instr_in, PC_plus2_in, Fetch_valid, Stall, Flush,
    input  Instr_out, PC_plus2_out, Valid_out, Opcode, Imme_9b, Rd, Rs, Rt,
           Halt_pending, Halt_seen, Fetch_stop
  );

  modport slave (
    input  Instr_in, PC_plus2_in, Fetch_valid, Stall, Flush,
    output Instr_out, PC_plus2_out, Valid_out, Opcode, Imme_9b, Rd, Rs, Rt,
           Halt_pending, Halt_seen, Fetch_stop
  );
`endif

endinterface

// File: rtl/if_id_stage_dff_en_clr.sv
// -----------------------------------------------------------------------------
// dff_en_clr
// Width-parameterised register with synchronous clear-to-value and enable.
// Clear has priority over enable; with neither asserted the value holds.
//   clk     : rising-edge clock
//   clr_i   : load CLR_VAL on the next edge
//   en_i    : load d_i on the next edge (when not clearing)
//   d_i     : data in
//   q_o     : registered data out
// -----------------------------------------------------------------------------
module dff_en_clr #(
  parameter int           W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr_i) begin
      data_d = CLR_VAL;
    end else if (en_i) begin
      data_d = d_i;
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
// IF/ID pipeline register of the WISC-F18 core. Captures the fetched
// instruction and PC+2, slices decode fields, and tracks a sticky HLT that
// freezes fetch.
//   clk  : core clock, rising edge
//   rst  : synchronous active-high reset (overrides everything)
//   bus  : if_id_stage_if.slave
//          in : Instr_in, PC_plus2_in, Fetch_valid, Stall, Flush
//          out: Instr_out, PC_plus2_out, Valid_out, Opcode, Imme_9b, Rd, Rs,
//               Rt, Halt_pending, Halt_seen, Fetch_stop
// Optional macro IF_ID_PERF_CNT_EN adds saturating 16-bit Bubble_cnt and
// Stall_cnt outputs on the bus.
// Update priority per edge: rst > Flush > Stall > Halt_seen > load.
// -----------------------------------------------------------------------------
module if_id_stage #(
  parameter int                 INSTR_W   = 16,
  parameter int                 PC_W      = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = wisc_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  if_id_stage_if.slave bus
);
  import wisc_pkg::*;

  logic               advance;
  logic               load;
  logic               bubble;
  logic               halt_pending;
  logic               halt_seen_q;
  logic               halt_seen_d;
  logic [INSTR_W-1:0] instr_q;
  logic [PC_W-1:0]    pc_q;
  logic               valid_q;

  // Neither flushing nor stalling: the current ID contents move on.
  assign advance = !bus.Flush && !bus.Stall;
  assign load    = advance && !halt_seen_q && bus.Fetch_valid;
  // A bubble replaces the contents on flush, on a miss, or once halted.
  assign bubble  = bus.Flush || (advance && !load);

  assign halt_pending = valid_q && (instr_q[OPC_HI -: 4] == OP_HLT);
  assign halt_seen_d  = halt_seen_q || (halt_pending && advance);

  // ---- IF -> ID register boundary ----
  dff_en_clr #(.W(INSTR_W), .CLR_VAL(NOP_INSTR)) u_instr (
    .clk   (clk),
    .clr_i (rst || bubble),
    .en_i  (load),
    .d_i   (bus.Instr_in),
    .q_o   (instr_q)
  );

  // PC+2 is only cleared by reset; bubbles leave it holding.
  dff_en_clr #(.W(PC_W), .CLR_VAL('0)) u_pc (
    .clk   (clk),
    .clr_i (rst),
    .en_i  (load),
    .d_i   (bus.PC_plus2_in),
    .q_o   (pc_q)
  );

  dff_en_clr #(.W(1), .CLR_VAL(1'b0)) u_valid (
    .clk   (clk),
    .clr_i (rst || bubble),
    .en_i  (load),
    .d_i   (1'b1),
    .q_o   (valid_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_seen_q <= 1'b0;
    end else begin
      halt_seen_q <= halt_seen_d;
    end
  end

  // ---- ID decode field slices ----
  assign bus.Instr_out    = instr_q;
  assign bus.PC_plus2_out = pc_q;
  assign bus.Valid_out    = valid_q;
  assign bus.Opcode       = instr_q[OPC_HI -: 4];
  assign bus.Imme_9b      = instr_q[IMM9_W-1:0];
  assign bus.Rd           = instr_q[RD_LO +: 4];
  assign bus.Rs           = instr_q[RS_LO +: 4];
  assign bus.Rt           = instr_q[RT_LO +: 4];
  assign bus.Halt_pending = halt_pending;
  assign bus.Halt_seen    = halt_seen_q;
  assign bus.Fetch_stop   = halt_seen_q;

`ifdef IF_ID_PERF_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] bubble_cnt_q;
  logic [15:0] bubble_cnt_d;
  logic [15:0] stall_cnt_q;
  logic [15:0] stall_cnt_d;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    if (bubble) begin
      bubble_cnt_d = sat_inc16(bubble_cnt_q);
    end
    if (bus.Stall && !bus.Flush) begin
      stall_cnt_d = sat_inc16(stall_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= 16'h0000;
      stall_cnt_q  <= 16'h0000;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.Bubble_cnt = bubble_cnt_q;
  assign bus.Stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage
// Self-checking bench for if_id_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the IF/ID register.
// Honors IF_ID_PERF_CNT_EN when defined.
// -----------------------------------------------------------------------------
module tb_if_id_stage;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  if_id_stage_if #(.INSTR_W(16), .PC_W(16)) bus ();

  if_id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [15:0] m_instr;
  logic [15:0] m_pc;
  logic        m_valid;
  logic        m_halt;
  int          m_bcnt;
  int          m_scnt;

  // Applies one clock edge of the documented behaviour to the model, using
  // the inputs as they stand at that edge.
  task automatic model_edge();
    logic hlt_advances;
    if (rst) begin
      m_instr = 16'h0000; m_pc = 16'h0000; m_valid = 1'b0; m_halt = 1'b0;
      m_bcnt = 0; m_scnt = 0;
    end else begin
      hlt_advances = m_valid && ((m_instr >> 12) == 16'd15) && !bus.Stall && !bus.Flush;
      if (bus.Flush) begin
        m_instr = 16'h0000; m_valid = 1'b0; m_bcnt++;
      end else if (bus.Stall) begin
        m_scnt++;
      end else if (m_halt || !bus.Fetch_valid) begin
        m_instr = 16'h0000; m_valid = 1'b0; m_bcnt++;
      end else begin
        m_instr = bus.Instr_in; m_pc = bus.PC_plus2_in; m_valid = 1'b1;
      end
      if (hlt_advances) m_halt = 1'b1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [15:0] ins, input logic [15:0] pc,
                       input logic fv, input logic st, input logic fl);
    bus.Instr_in = ins; bus.PC_plus2_in = pc;
    bus.Fetch_valid = fv; bus.Stall = st; bus.Flush = fl;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(16'hF000, 16'h1234, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.Instr_out !== 16'h0000) begin errors++; $display("FAIL reset_instr got %h want 0000", bus.Instr_out); end
      checks++; if (bus.PC_plus2_out !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", bus.PC_plus2_out); end
      checks++; if ({bus.Valid_out, bus.Halt_seen, bus.Fetch_stop, bus.Halt_pending} !== 4'b0000) begin
        errors++; $display("FAIL reset_ctrl got %b want 0000", {bus.Valid_out, bus.Halt_seen, bus.Fetch_stop, bus.Halt_pending}); end
      checks++; if ({bus.Opcode, bus.Imme_9b, bus.Rd} !== 17'h0) begin errors++; $display("FAIL reset_fields got %h want 0", {bus.Opcode, bus.Imme_9b, bus.Rd}); end
    end
    rst = 1'b0;
    drive(16'hA123, 16'h0002, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if (bus.Instr_out !== 16'hA123) begin errors++; $display("FAIL load_instr got %h want a123", bus.Instr_out); end
    checks++; if (bus.Opcode !== 4'hA) begin errors++; $display("FAIL load_opcode got %h want a", bus.Opcode); end
    checks++; if (bus.Imme_9b !== 9'h123) begin errors++; $display("FAIL load_imm got %h want 123", bus.Imme_9b); end
    checks++; if (bus.Rd !== 4'h1) begin errors++; $display("FAIL load_rd got %h want 1", bus.Rd); end
    checks++; if (bus.Valid_out !== 1'b1) begin errors++; $display("FAIL load_valid got %b want 1", bus.Valid_out); end
    checks++; if (bus.PC_plus2_out !== 16'h0002) begin errors++; $display("FAIL load_pc got %h want 0002", bus.PC_plus2_out); end
  endtask

  task automatic test_stall();
    drive(16'h1234, 16'h0004, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if (bus.Instr_out !== 16'h1234) begin errors++; $display("FAIL stall_pre got %h want 1234", bus.Instr_out); end
    drive(16'h5678, 16'h0006, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({bus.Instr_out, bus.PC_plus2_out, bus.Valid_out} !== {16'h1234, 16'h0004, 1'b1}) begin
        errors++; $display("FAIL stall_hold cyc %0d got %h/%h/%b want 1234/0004/1", i, bus.Instr_out, bus.PC_plus2_out, bus.Valid_out); end
    end
    bus.Stall = 1'b0;
    step();
    checks++; if ({bus.Instr_out, bus.PC_plus2_out} !== {16'h5678, 16'h0006}) begin
      errors++; $display("FAIL stall_release got %h/%h want 5678/0006", bus.Instr_out, bus.PC_plus2_out); end
  endtask

  task automatic test_flush_beats_stall();
    drive(16'hC1F0, 16'h0008, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if ({bus.Rd, bus.Rs, bus.Rt, bus.Imme_9b} !== {4'h1, 4'hF, 4'h0, 9'h1F0}) begin
      errors++; $display("FAIL flush_pre_fields got %h %h %h %h want 1 f 0 1f0", bus.Rd, bus.Rs, bus.Rt, bus.Imme_9b); end
    drive(16'h1111, 16'h000A, 1'b1, 1'b1, 1'b1);
    step();
    checks++; if (bus.Instr_out !== 16'h0000) begin errors++; $display("FAIL flush_instr got %h want 0000", bus.Instr_out); end
    checks++; if (bus.Valid_out !== 1'b0) begin errors++; $display("FAIL flush_valid got %b want 0", bus.Valid_out); end
    checks++; if (bus.PC_plus2_out !== 16'h0008) begin errors++; $display("FAIL flush_pc got %h want 0008", bus.PC_plus2_out); end
    bus.Stall = 1'b0; bus.Flush = 1'b0;
  endtask

  task automatic test_miss();
    drive(16'h7777, 16'h000C, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if ({bus.Instr_out, bus.Valid_out, bus.PC_plus2_out} !== {16'h0000, 1'b0, 16'h0008}) begin
        errors++; $display("FAIL miss_bubble cyc %0d got %h/%b/%h want 0000/0/0008", i, bus.Instr_out, bus.Valid_out, bus.PC_plus2_out); end
    end
    drive(16'h2345, 16'h000E, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if ({bus.Instr_out, bus.Valid_out, bus.PC_plus2_out} !== {16'h2345, 1'b1, 16'h000E}) begin
      errors++; $display("FAIL miss_recover got %h/%b/%h want 2345/1/000e", bus.Instr_out, bus.Valid_out, bus.PC_plus2_out); end
  endtask

  task automatic test_halt();
    drive(16'hF000, 16'h0010, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if ({bus.Halt_pending, bus.Halt_seen, bus.Fetch_stop} !== 3'b100) begin
      errors++; $display("FAIL halt_pending got %b want 100", {bus.Halt_pending, bus.Halt_seen, bus.Fetch_stop}); end
    bus.Fetch_valid = 1'b0;
    step();
    checks++; if ({bus.Halt_seen, bus.Fetch_stop, bus.Valid_out} !== 3'b110) begin
      errors++; $display("FAIL halt_set got %b want 110", {bus.Halt_seen, bus.Fetch_stop, bus.Valid_out}); end
    drive(16'h3333, 16'h0012, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if ({bus.Valid_out, bus.Instr_out, bus.Halt_seen} !== {1'b0, 16'h0000, 1'b1}) begin
        errors++; $display("FAIL halt_frozen cyc %0d got %b/%h/%b want 0/0000/1", i, bus.Valid_out, bus.Instr_out, bus.Halt_seen); end
    end
    rst = 1'b1; step(); rst = 1'b0;
    checks++; if (bus.Halt_seen !== 1'b0) begin errors++; $display("FAIL halt_rst got %b want 0", bus.Halt_seen); end
    // HLT squashed by a flush must never register as seen.
    drive(16'hF000, 16'h0020, 1'b1, 1'b0, 1'b0);
    step();
    drive(16'h1111, 16'h0022, 1'b1, 1'b0, 1'b1);
    step();
    bus.Flush = 1'b0;
    step(); step();
    checks++; if ({bus.Halt_seen, bus.Valid_out, bus.Instr_out} !== {1'b0, 1'b1, 16'h1111}) begin
      errors++; $display("FAIL halt_flushed got %b/%b/%h want 0/1/1111", bus.Halt_seen, bus.Valid_out, bus.Instr_out); end
    // HLT held by a stall does not set until it actually advances.
    drive(16'hF000, 16'h0024, 1'b1, 1'b0, 1'b0);
    step();
    bus.Stall = 1'b1;
    step(); step();
    checks++; if ({bus.Halt_pending, bus.Halt_seen} !== 2'b10) begin
      errors++; $display("FAIL halt_stalled got %b want 10", {bus.Halt_pending, bus.Halt_seen}); end
    bus.Stall = 1'b0; bus.Fetch_valid = 1'b0;
    step();
    checks++; if (bus.Halt_seen !== 1'b1) begin errors++; $display("FAIL halt_after_stall got %b want 1", bus.Halt_seen); end
    rst = 1'b1; step(); rst = 1'b0;
  endtask

`ifdef IF_ID_PERF_CNT_EN
  task automatic test_perf();
    rst = 1'b1; drive(16'h4444, 16'h0030, 1'b1, 1'b0, 1'b0); step(); rst = 1'b0;
    checks++; if ({bus.Bubble_cnt, bus.Stall_cnt} !== 32'h0) begin
      errors++; $display("FAIL perf_rst got %h/%h want 0/0", bus.Bubble_cnt, bus.Stall_cnt); end
    bus.Flush = 1'b1; step(); step(); bus.Flush = 1'b0;
    bus.Fetch_valid = 1'b0; step(); step(); step();
    bus.Stall = 1'b1; for (int i = 0; i < 4; i++) step(); bus.Stall = 1'b0;
    checks++; if ({bus.Bubble_cnt, bus.Stall_cnt} !== {16'd5, 16'd4}) begin
      errors++; $display("FAIL perf_count got %0d/%0d want 5/4", bus.Bubble_cnt, bus.Stall_cnt); end
    for (int i = 0; i < 70000; i++) step();
    checks++; if ({bus.Bubble_cnt, bus.Stall_cnt} !== {16'hFFFF, 16'd4}) begin
      errors++; $display("FAIL perf_sat got %h/%0d want ffff/4", bus.Bubble_cnt, bus.Stall_cnt); end
    step();
    checks++; if (bus.Bubble_cnt !== 16'hFFFF) begin errors++; $display("FAIL perf_nowrap got %h want ffff", bus.Bubble_cnt); end
  endtask
`endif

  task automatic test_random();
    logic [15:0] ins;
    for (int i = 0; i < 400; i++) begin
      ins = 16'($urandom);
      if ($urandom_range(0, 5) == 0) ins[15:12] = 4'hF;
      rst = ($urandom_range(0, 39) == 0);
      drive(ins, 16'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
      step();
      checks++; if ({bus.Instr_out, bus.PC_plus2_out, bus.Valid_out} !== {m_instr, m_pc, m_valid}) begin
        errors++; $display("FAIL rand_regs cyc %0d got %h/%h/%b want %h/%h/%b", i,
                           bus.Instr_out, bus.PC_plus2_out, bus.Valid_out, m_instr, m_pc, m_valid); end
      checks++; if ({bus.Opcode, bus.Rd, bus.Rs, bus.Rt, bus.Imme_9b} !==
                    {4'(m_instr >> 12), 4'((m_instr >> 8) % 16), 4'((m_instr >> 4) % 16), 4'(m_instr % 16), 9'(m_instr % 512)}) begin
        errors++; $display("FAIL rand_fields cyc %0d got %h %h %h %h %h instr %h", i,
                           bus.Opcode, bus.Rd, bus.Rs, bus.Rt, bus.Imme_9b, m_instr); end
      checks++; if ({bus.Halt_pending, bus.Halt_seen, bus.Fetch_stop} !==
                    {(m_valid && (m_instr >> 12) == 16'd15), m_halt, m_halt}) begin
        errors++; $display("FAIL rand_halt cyc %0d got %b want %b%b%b", i,
                           {bus.Halt_pending, bus.Halt_seen, bus.Fetch_stop},
                           (m_valid && (m_instr >> 12) == 16'd15), m_halt, m_halt); end
`ifdef IF_ID_PERF_CNT_EN
      checks++; if ({bus.Bubble_cnt, bus.Stall_cnt} !==
                    {16'((m_bcnt > 65535) ? 65535 : m_bcnt), 16'((m_scnt > 65535) ? 65535 : m_scnt)}) begin
        errors++; $display("FAIL rand_perf cyc %0d got %0d/%0d want %0d/%0d", i,
                           bus.Bubble_cnt, bus.Stall_cnt, m_bcnt, m_scnt); end
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    drive(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_stall();
    test_flush_beats_stall();
    test_miss();
    test_halt();
`ifdef IF_ID_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
